// File: rtl/reg_array_assign_pkg.sv
// Shared encodings and the index legality helper for the assignable register array.
package reg_array_assign_pkg;

   typedef enum logic [1:0] {
      OP_WRITE    = 2'b00,
      OP_ASSIGN   = 2'b01,
      OP_DEASSIGN = 2'b10,
      OP_NOP      = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_RANGE   = 2'b01,
      ERR_UNKNOWN = 2'b10
   } err_e;

   function automatic logic idx_legal(input int unsigned idx,
                                      input int unsigned lo,
                                      input int unsigned depth);
      return (idx >= lo) && (idx < lo + depth);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// NREQ-way round-robin arbiter: one-hot grant to the first valid requester at or
// after the pointer; the pointer moves past the winner whenever a grant is made.
module rr_arbiter #(
   parameter int NREQ = 2,
   localparam int PW = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   grant_idx,
   output logic            grant_any
);

   logic [PW-1:0] rr;
   logic [PW:0]   slot;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      slot      = '0;
      for (int i = 0; i < NREQ; i++) begin
         slot = {1'b0, rr} + (PW+1)'(i);
         if (slot >= (PW+1)'(NREQ)) slot = slot - (PW+1)'(NREQ);
         // Nothing is granted while reset is held.
         if (!grant_any && rst_n && req[slot[PW-1:0]]) begin
            grant_any               = 1'b1;
            grant[slot[PW-1:0]]     = 1'b1;
            grant_idx               = slot[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr <= '0;
      end else if (grant_any) begin
         rr <= (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
      end
   end

endmodule

// File: rtl/reg_array_assign_ctrl.sv
// Register array whose elements are written procedurally or held under a per-element
// continuous override (assign/deassign), with round-robin arbitration of requesters.
module reg_array_assign_ctrl
   import reg_array_assign_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int DEPTH  = 2,
   parameter int LO_IDX = 1,
   parameter int IDXW   = 2,
   parameter int NREQ   = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [2*NREQ-1:0]         req_op,
   input  logic [IDXW*NREQ-1:0]      req_idx,
   input  logic [WIDTH*NREQ-1:0]     req_data,
   input  logic [WIDTH*NREQ-1:0]     src_data,
   input  logic [IDXW-1:0]           rd_idx,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      err_valid,
   output logic [1:0]                err_code,
   output logic [$clog2(NREQ)-1:0]   err_req
);

   localparam int PW = $clog2(NREQ);

   // Handshake: a request transfers on an edge where req_valid and req_ready are both
   // high for that requester; ready is never raised without valid and is at most one-hot.
   logic [WIDTH-1:0] mem    [DEPTH];
   logic [DEPTH-1:0] own_v;
   logic [PW-1:0]    own_id [DEPTH];

   logic             accept;
   logic [PW-1:0]    gidx;
   logic [1:0]       sel_op;
   logic [IDXW-1:0]  sel_idx;
   logic [WIDTH-1:0] sel_data;
   logic             active;
   logic             idx_unknown;
   logic             idx_ok;
   logic             bad;
   logic [DEPTH-1:0] hit;
   logic [WIDTH-1:0] rd_next;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .grant     (req_ready),
      .grant_idx (gidx),
      .grant_any (accept)
   );

   assign sel_op      = req_op[gidx*2 +: 2];
   assign sel_idx     = req_idx[gidx*IDXW +: IDXW];
   assign sel_data    = req_data[gidx*WIDTH +: WIDTH];
   assign active      = accept && (sel_op != OP_NOP);
   assign idx_unknown = $isunknown(sel_idx);
   assign idx_ok      = idx_legal(32'(sel_idx), LO_IDX, DEPTH);
   assign bad         = active && (idx_unknown || !idx_ok);

   always_comb begin
      hit = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (sel_idx == IDXW'(LO_IDX + k)) hit[k] = active && !idx_unknown && idx_ok;
      end
   end

   // Deassign beats the override refresh; an owned element ignores writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         own_v <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            mem[k]    <= '0;
            own_id[k] <= '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (hit[k] && sel_op == OP_DEASSIGN) begin
               own_v[k] <= 1'b0;
            end else if (own_v[k]) begin
               mem[k] <= src_data[own_id[k]*WIDTH +: WIDTH];
            end else if (hit[k] && sel_op == OP_WRITE) begin
               mem[k] <= sel_data;
            end
            if (hit[k] && sel_op == OP_ASSIGN) begin
               own_v[k]  <= 1'b1;
               own_id[k] <= gidx;
            end
         end
      end
   end

   always_comb begin
`ifdef SYNTHESIS
      rd_next = '0;
`else
      rd_next = 'x;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         if (rd_idx == IDXW'(LO_IDX + k)) rd_next = mem[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data   <= '0;
         err_valid <= 1'b0;
         err_code  <= ERR_NONE;
         err_req   <= '0;
      end else begin
         rd_data   <= rd_next;
         err_valid <= bad;
         err_code  <= !bad ? ERR_NONE : (idx_unknown ? ERR_UNKNOWN : ERR_RANGE);
         err_req   <= bad ? gidx : '0;
      end
   end

endmodule

// File: tb/tb_reg_array_assign_ctrl.sv
// Bench for reg_array_assign_ctrl: hand-computed vector table for the directed cases,
// then randomized traffic against an array-level reference model.
module tb_reg_array_assign_ctrl;

   localparam int WIDTH  = 2;
   localparam int DEPTH  = 2;
   localparam int LO_IDX = 1;
   localparam int IDXW   = 2;
   localparam int NREQ   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [2*NREQ-1:0]     req_op;
   logic [IDXW*NREQ-1:0]  req_idx;
   logic [WIDTH*NREQ-1:0] req_data;
   logic [WIDTH*NREQ-1:0] src_data;
   logic [IDXW-1:0]       rd_idx;
   logic [WIDTH-1:0]      rd_data;
   logic                  err_valid;
   logic [1:0]            err_code;
   logic [0:0]            err_req;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: element values, ownership and the round-robin pointer.
   logic [WIDTH-1:0] m_mem    [DEPTH];
   bit               m_own_v  [DEPTH];
   int               m_own_id [DEPTH];
   int               m_rr;

   typedef struct {
      logic [1:0] v;
      logic [3:0] op;
      logic [3:0] idx;
      logic [3:0] data;
      logic [3:0] src;
      logic [1:0] ridx;
      logic [1:0] e_ready;
      logic [1:0] e_code;
      bit         chk_rd;
      logic [1:0] e_rd;
   } vec_t;

   vec_t tbl [26];

   reg_array_assign_ctrl #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .LO_IDX(LO_IDX), .IDXW(IDXW), .NREQ(NREQ)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_idx   (req_idx),
      .req_data  (req_data),
      .src_data  (src_data),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data),
      .err_valid (err_valid),
      .err_code  (err_code),
      .err_req   (err_req)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < DEPTH; k++) begin
         m_mem[k]    = '0;
         m_own_v[k]  = 1'b0;
         m_own_id[k] = 0;
      end
      m_rr = 0;
   endtask

   // Holds reset for one edge with every requester asking; nothing may be granted.
   task automatic reset_cycle();
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_op    = 4'b1111;
      req_idx   = 4'b0101;
      #1;
      check("reset_ready", req_ready, 0);
      @(posedge clk);
      #1;
      model_reset();
      check("reset_rd_data", rd_data, 0);
      check("reset_err_valid", err_valid, 0);
      check("reset_err_code", err_code, 0);
      check("reset_err_req", err_req, 0);
      rst_n = 1'b1;
   endtask

   // Drives one cycle, checks the grant before the edge and the registered outputs after.
   task automatic run_cycle(input logic [1:0] v, input logic [3:0] op, input logic [3:0] idx,
                            input logic [3:0] data, input logic [3:0] src,
                            input logic [1:0] ridx, output logic [1:0] got_ready);
      logic [WIDTH-1:0] pre [DEPTH];
      int               g;
      int               k;
      logic [1:0]       o;
      logic [1:0]       ix;
      bit               e_v;
      logic [1:0]       e_code;
      int               e_req;
      bit               rd_chk;
      logic [1:0]       e_rd;
      req_valid = v;
      req_op    = op;
      req_idx   = idx;
      req_data  = data;
      src_data  = src;
      rd_idx    = ridx;
      #1;
      g = -1;
      for (int i = 0; i < NREQ; i++) begin
         int j;
         j = (m_rr + i) % NREQ;
         if (g < 0 && v[j]) g = j;
      end
      got_ready = req_ready;
      check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
      check("ready_onehot0", {31'b0, $onehot0(req_ready)}, 1);

      pre    = m_mem;
      rd_chk = (ridx >= LO_IDX) && (ridx < LO_IDX + DEPTH);
      e_rd   = '0;
      if (rd_chk) e_rd = pre[ridx - LO_IDX];
      for (int q = 0; q < DEPTH; q++) begin
         if (m_own_v[q]) m_mem[q] = src[m_own_id[q]*WIDTH +: WIDTH];
      end
      e_v = 1'b0;
      e_code = 2'b00;
      e_req = 0;
      if (g >= 0) begin
         m_rr = (g + 1) % NREQ;
         o    = op[g*2 +: 2];
         ix   = idx[g*IDXW +: IDXW];
         if (o != 2'b11) begin
            if ($isunknown(ix)) begin
               e_v = 1'b1; e_code = 2'b10; e_req = g;
            end else if (ix < LO_IDX || ix >= LO_IDX + DEPTH) begin
               e_v = 1'b1; e_code = 2'b01; e_req = g;
            end else begin
               k = ix - LO_IDX;
               case (o)
                  2'b00:   if (!m_own_v[k]) m_mem[k] = data[g*WIDTH +: WIDTH];
                  2'b01:   begin m_own_v[k] = 1'b1; m_own_id[k] = g; end
                  default: begin m_own_v[k] = 1'b0; m_mem[k] = pre[k]; end
               endcase
            end
         end
      end

      @(posedge clk);
      #1;
      check("err_valid", err_valid, e_v);
      check("err_code", err_code, e_code);
      check("err_req", err_req, e_req);
      if (rd_chk) check("rd_data", rd_data, e_rd);
   endtask

   initial begin
      logic [3:0] xidx;
      logic [1:0] unk_code;
      logic [1:0] r;
      xidx     = 4'b01xx;
      unk_code = $isunknown(xidx[1:0]) ? 2'b10 : 2'b01;

      //            v      op       idx      data     src      ridx  rdy    code      chk  rd
      tbl[0]  = '{2'b01, 4'b1100, 4'b0100, 4'b0001, 4'b0000, 2'd1, 2'b01, 2'b01,    1'b1, 2'd0};
      tbl[1]  = '{2'b01, 4'b1100, 4'b0111, 4'b0001, 4'b0000, 2'd2, 2'b01, 2'b01,    1'b1, 2'd0};
      tbl[2]  = '{2'b00, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 2'd1, 2'b00, 2'b00,    1'b1, 2'd0};
      tbl[3]  = '{2'b10, 4'b0111, 4'b1001, 4'b0000, 4'b0100, 2'd2, 2'b10, 2'b00,    1'b1, 2'd0};
      tbl[4]  = '{2'b00, 4'b1111, 4'b0101, 4'b0000, 4'b0100, 2'd2, 2'b00, 2'b00,    1'b1, 2'd0};
      tbl[5]  = '{2'b00, 4'b1111, 4'b0101, 4'b0000, 4'b1000, 2'd2, 2'b00, 2'b00,    1'b1, 2'd1};
      tbl[6]  = '{2'b00, 4'b1111, 4'b0101, 4'b0000, 4'b1000, 2'd2, 2'b00, 2'b00,    1'b1, 2'd2};
      tbl[7]  = '{2'b01, 4'b1110, 4'b0110, 4'b0000, 4'b1100, 2'd1, 2'b01, 2'b00,    1'b1, 2'd0};
      tbl[8]  = '{2'b00, 4'b1111, 4'b0101, 4'b0000, 4'b1100, 2'd2, 2'b00, 2'b00,    1'b1, 2'd2};
      tbl[9]  = '{2'b00, 4'b1111, 4'b0101, 4'b0000, 4'b1100, 2'd2, 2'b00, 2'b00,    1'b1, 2'd2};
      tbl[10] = '{2'b10, 4'b0111, 4'b0101, 4'b0000, 4'b0100, 2'd1, 2'b10, 2'b00,    1'b1, 2'd0};
      tbl[11] = '{2'b01, 4'b1100, 4'b0101, 4'b0011, 4'b0100, 2'd1, 2'b01, 2'b00,    1'b1, 2'd0};
      tbl[12] = '{2'b00, 4'b1111, 4'b0101, 4'b0000, 4'b0100, 2'd1, 2'b00, 2'b00,    1'b1, 2'd1};
      tbl[13] = '{2'b10, 4'b1011, 4'b0101, 4'b0000, 4'b0100, 2'd1, 2'b10, 2'b00,    1'b1, 2'd1};
      tbl[14] = '{2'b01, 4'b1100, 4'b0101, 4'b0011, 4'b0000, 2'd1, 2'b01, 2'b00,    1'b1, 2'd1};
      tbl[15] = '{2'b00, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 2'd1, 2'b00, 2'b00,    1'b1, 2'd3};
      tbl[16] = '{2'b01, 4'b1101, xidx,    4'b0000, 4'b0000, 2'd1, 2'b01, unk_code, 1'b1, 2'd3};
      tbl[17] = '{2'b00, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 2'd1, 2'b00, 2'b00,    1'b1, 2'd3};
      tbl[18] = '{2'b10, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 2'd2, 2'b10, 2'b00,    1'b1, 2'd2};
      tbl[19] = '{2'b11, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 2'd2, 2'b01, 2'b00,    1'b1, 2'd2};
      tbl[20] = '{2'b11, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 2'd2, 2'b10, 2'b00,    1'b1, 2'd2};
      tbl[21] = '{2'b11, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 2'd2, 2'b01, 2'b00,    1'b1, 2'd2};
      tbl[22] = '{2'b11, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 2'd2, 2'b10, 2'b00,    1'b1, 2'd2};
      tbl[23] = '{2'b01, 4'b1101, 4'b0110, 4'b0000, 4'b0011, 2'd2, 2'b01, 2'b00,    1'b1, 2'd2};
      tbl[24] = '{2'b00, 4'b1111, 4'b0101, 4'b0000, 4'b0011, 2'd2, 2'b00, 2'b00,    1'b1, 2'd2};
      tbl[25] = '{2'b00, 4'b1111, 4'b0101, 4'b0000, 4'b0011, 2'd2, 2'b00, 2'b00,    1'b1, 2'd3};

      req_valid = '0;
      req_op    = 4'b1111;
      req_idx   = 4'b0101;
      req_data  = '0;
      src_data  = '0;
      rd_idx    = 2'd1;
      rst_n     = 1'b0;
      @(posedge clk);
      #1;
      reset_cycle();

      for (int i = 0; i < 26; i++) begin
         run_cycle(tbl[i].v, tbl[i].op, tbl[i].idx, tbl[i].data, tbl[i].src, tbl[i].ridx, r);
         check($sformatf("tbl%0d_ready", i), r, tbl[i].e_ready);
         check($sformatf("tbl%0d_code", i), err_code, tbl[i].e_code);
         if (tbl[i].chk_rd) check($sformatf("tbl%0d_rd", i), rd_data, tbl[i].e_rd);
      end

      // Reset while element 2 is overridden: it must read 0 whatever src_data does.
      reset_cycle();
      for (int s = 1; s < 4; s++) begin
         run_cycle(2'b00, 4'b1111, 4'b0101, 4'b0000, 4'(s), 2'd2, r);
         check($sformatf("rst_override_%0d", s), rd_data, 0);
      end

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 63) == 0) begin
            reset_cycle();
         end else begin
            run_cycle(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), r);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reg_array_assign_ctrl.md
# reg_array_assign_ctrl

Controller for a small register array whose elements can be written procedurally or held under a continuous override, mirroring Verilog `assign`/`deassign` on array elements. It round-robin arbitrates element operations from `NREQ` requesters and owns the per-element override table. Out-of-range and unknown indices never disturb storage and are reported. It sits between requester engines and any logic reading the array.

## Interface
- `WIDTH`, 2, element width in bits
- `DEPTH`, 2, number of elements
- `LO_IDX`, 1, lowest legal index; legal range is `LO_IDX`..`LO_IDX+DEPTH-1`
- `IDXW`, 2, index width; indices are unsigned
- `NREQ`, 2, number of requesters, at least 2
- `clk`  in  1  clock; one clock domain
- `rst_n`  in  1  reset; synchronous, active-low
- `req_valid`  in  `NREQ`  request valid, one bit per requester
- `req_ready`  out  `NREQ`  grant/accept, one-hot or zero
- `req_op`  in  `2*NREQ`  operation: 00 write, 01 assign, 10 deassign, 11 nop
- `req_idx`  in  `IDXW*NREQ`  element index
- `req_data`  in  `WIDTH*NREQ`  data for a write
- `src_data`  in  `WIDTH*NREQ`  live override source, one per requester
- `rd_idx`  in  `IDXW`  read index
- `rd_data`  out  `WIDTH`  registered read data
- `err_valid`  out  1  one-cycle error pulse
- `err_code`  out  2  error code: 01 out-of-range, 10 unknown index, 00 none
- `err_req`  out  `$clog2(NREQ)`  requester that caused the error

## Operation
- **Arbitration**
  - Round-robin pointer `rr`.
  - Grant goes to the first valid requester at or after `rr`.
  - `req_ready` is asserted only for the granted requester, combinationally.
  - After a grant, `rr` moves to the granted requester + 1, modulo `NREQ`.
  - At most one operation is accepted per cycle.
- **Index check**
  - An index is legal only if it lies in the range above.
  - Any X/Z bit in the index gives code 10; this takes precedence over range checking.
  - A bad index gives a single `err_valid` pulse with `err_req` set.
  - The request is still accepted, so there is no deadlock.
  - A bad index causes no change to storage or ownership.
- **write**: if the element is not overridden, `mem[idx] <= req_data`. If it is overridden, the write is silently dropped; this is not an error.
- **assign**
  - Sets `own_v[idx]=1` and `own_id[idx]=requester`.
  - Last assign wins: it replaces any existing owner.
  - Each cycle, an owned element loads `src_data[own_id]`.
- **deassign**
  - Clears `own_v[idx]`.
  - The element keeps its last value until the next write.
  - Deassign of an unowned element, or by a non-owner, still clears ownership; this matches Verilog semantics.
- **nop**: accepted, no effect.
- **Read**: `rd_data <= mem[rd_idx]`. An illegal or unknown `rd_idx` gives all-X in simulation and 0 in synthesis; the rule is fixed by the `SYNTHESIS` define.

## Timing
- **Reset (`rst_n` low at a clock edge)**
  - All `mem` = 0.
  - All `own_v` = 0.
  - `rr` = 0.
  - `rd_data` = 0.
  - `err_valid` = 0, `err_code` = 0, `err_req` = 0.
- During reset, `req_ready` = 0.
- Reset mid-override drops all ownership; `src_data` is ignored from the next edge.
- **Latency**
  - write, assign and deassign take effect at the edge that accepts them.
  - Write data is visible on `rd_data` two edges after acceptance (storage, then read register).
  - For an assign accepted at edge N, the element holds `src_data` sampled at edge N+1 and tracks it every cycle after.
  - An error pulse is asserted in the cycle after acceptance.
- **Simultaneous events**
  - A write to element k in the same cycle as a deassign of k: impossible, since there is one grant per cycle.
  - Override refresh and a deassign on the same edge: deassign wins. The element keeps its pre-edge value and does not load `src_data`.

## Structure
- Package `reg_array_assign_pkg` holds:
  - op encodings `OP_WRITE`, `OP_ASSIGN`, `OP_DEASSIGN`, `OP_NOP`
  - error codes `ERR_NONE`, `ERR_RANGE`, `ERR_UNKNOWN`
  - the `idx_legal` function
- One sub-module, `rr_arbiter`: `NREQ`-way round-robin, one-hot grant, pointer update on accept.
- Storage and override table stay in the top module.

## Test plan
1. **Out-of-range write**
   - Stimulus: after reset, requester 0 writes idx 0, data 1.
   - Response: `err_code`=01; elements 1 and 2 read 0.
   - Then idx 3, data 1: same result.
2. **Assign tracking**
   - Stimulus: requester 1 assigns idx 2; `src_data[1]`=1, then 2.
   - Response: `rd_data`(2) follows 1 then 2; element 1 stays 0.
   - Then deassign: element 2 holds 2.
3. **Write blocked by override**
   - Stimulus: while idx 1 is assigned with `src_data`=1, requester 0 writes 3 to idx 1.
   - Response: element stays 1, no error.
   - After deassign, the same write gives 3.
4. **Unknown index**
   - Stimulus: assign to idx `2'bx`.
   - Response: `err_code`=10; all elements unchanged; no ownership set.
5. **Round-robin fairness**
   - Stimulus: both requesters valid with nop for 4 cycles.
   - Response: grants alternate 0,1,0,1; `req_ready` is never two-hot.
6. **Reset mid-override**
   - Stimulus: idx 2 assigned, `src_data`=3; pulse `rst_n` low for one cycle.
   - Response: element 2 reads 0 and stays 0 while `src_data` changes.
